// File: rtl/algorithmic_8bit_barrel_shifter.sv
// algorithmic_8bit_barrel_shifter: registered log-shifter (SLL/SRL/SRA/ROL by base2exp); ports clk, rst, in_valid, data_in, base2exp, mode -> data_out, out_valid
module algorithmic_8bit_barrel_shifter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N-1:0]         data_in,
  input  logic [$clog2(N)-1:0] base2exp,
  input  logic [1:0]           mode,
  output logic [N-1:0]         data_out,
  output logic                 out_valid
);
  localparam int S = $clog2(N);
  for (genvar i = 0; i < S; i++) begin : g_stage
    localparam int A = 1 << i;
    logic [N-1:0] a, sh, q;
    if (i == 0) begin : g_first
      assign a = data_in;
    end else begin : g_next
      assign a = g_stage[i-1].q;
    end
    always_comb sh = mode == 2'b00 ? {a[N-1-A:0], {A{1'b0}}} :
                     mode == 2'b01 ? {{A{1'b0}}, a[N-1:A]} :
                     mode == 2'b10 ? {{A{a[N-1]}}, a[N-1:A]} :
                                     {a[N-1-A:0], a[N-1:N-A]};
    assign q = base2exp[i] ? sh : a;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) data_out <= g_stage[S-1].q;
    end
  end
endmodule

// File: tb/tb_algorithmic_8bit_barrel_shifter.sv
// tb_algorithmic_8bit_barrel_shifter: directed table, stream, hold, reset and exhaustive/random checks
module tb_algorithmic_8bit_barrel_shifter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  data_in = '0;
  logic [2:0]  base2exp = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  data_out;
  logic        out_valid;
  logic [31:0] d32 = '0;
  logic [4:0]  k32 = '0;
  logic [31:0] q32;
  logic        v32;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  algorithmic_8bit_barrel_shifter u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .base2exp(base2exp), .mode(mode), .data_out(data_out), .out_valid(out_valid)
  );

  algorithmic_8bit_barrel_shifter #(.N(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(d32),
    .base2exp(k32), .mode(mode), .data_out(q32), .out_valid(v32)
  );

  typedef struct {
    logic [7:0] d;
    logic [2:0] k;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;

  function automatic logic [7:0] ref8(input logic [7:0] d, input logic [2:0] k, input logic [1:0] m);
    logic [15:0] t;
    logic [7:0] r;
    t = {d, d} >> (8 - int'(k));
    case (m)
      2'b00:   r = d << k;
      2'b01:   r = d >> k;
      2'b10:   r = $signed(d) >>> k;
      default: r = t[7:0];
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] d, input logic [4:0] k, input logic [1:0] m);
    logic [63:0] t;
    logic [31:0] r;
    t = {d, d} >> (32 - int'(k));
    case (m)
      2'b00:   r = d << k;
      2'b01:   r = d >> k;
      2'b10:   r = $signed(d) >>> k;
      default: r = t[31:0];
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] k, input logic [1:0] m);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    base2exp = k;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[16];

  initial begin
    vt[0]  = '{8'h00, 3'd2, 2'b00, 8'd0};
    vt[1]  = '{8'h05, 3'd2, 2'b00, 8'd20};
    vt[2]  = '{8'h05, 3'd3, 2'b00, 8'd40};
    vt[3]  = '{8'h05, 3'd7, 2'b00, 8'd128};
    vt[4]  = '{8'h80, 3'd2, 2'b01, 8'h20};
    vt[5]  = '{8'h80, 3'd2, 2'b10, 8'hE0};
    vt[6]  = '{8'h7F, 3'd7, 2'b01, 8'h00};
    vt[7]  = '{8'h7F, 3'd7, 2'b10, 8'h00};
    vt[8]  = '{8'h81, 3'd1, 2'b11, 8'h03};
    vt[9]  = '{8'hA5, 3'd4, 2'b11, 8'h5A};
    vt[10] = '{8'h3C, 3'd0, 2'b11, 8'h3C};
    vt[11] = '{8'hC3, 3'd0, 2'b10, 8'hC3};
    vt[12] = '{8'hFF, 3'd7, 2'b00, 8'h80};
    vt[13] = '{8'h80, 3'd7, 2'b10, 8'hFF};
    vt[14] = '{8'h01, 3'd7, 2'b11, 8'h80};
    vt[15] = '{8'h96, 3'd3, 2'b01, 8'h12};

    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 8'h05, 3'd2, 2'b00);
      chk("reset_data", {24'd0, data_out}, 32'd0);
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vt[i].d, vt[i].k, vt[i].m);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), {24'd0, data_out}, {24'd0, vt[i].e});
    end

    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 8'hFF, 3'd1, 2'b00);
      chk("hold_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_data", {24'd0, data_out}, {24'd0, vt[15].e});
    end

    drive(1'b1, 8'h05, 3'd2, 2'b00);
    chk("pre_rst_data", {24'd0, data_out}, 32'd20);
    @(negedge clk);
    rst = 1'b1;
    data_in = 8'h07;
    @(posedge clk);
    #1;
    chk("midrst_data", {24'd0, data_out}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 8; k++)
        for (int d = 0; d < 256; d++) begin
          @(negedge clk);
          d32 = $urandom;
          k32 = 5'($urandom_range(0, 31));
          drive(1'b1, 8'(d), 3'(k), 2'(m));
          chk("sweep8", {24'd0, data_out}, {24'd0, ref8(8'(d), 3'(k), 2'(m))});
          if ((d & 15) == 0) begin
            chk("rand32", q32, ref32(d32, k32, 2'(m)));
            chk("rand32_valid", {31'd0, v32}, 32'd1);
          end
        end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
